// File: rtl/miner_serial_rx_pkg.sv
// Shared types and constants for the serial work-unit receiver.
package miner_serial_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int unsigned FRAME_BYTES   = 64;
  localparam logic [5:0]  LAST_BYTE_IDX = 6'd63;
  localparam logic [2:0]  LAST_BIT_IDX  = 3'd7;

endpackage

// File: rtl/miner_serial_rx_uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, falling-edge detect and a
// mid-bit sampling FSM. byte_valid_o/frame_err_o pulse one clock after the stop sample.
module uart_rx_byte
  import miner_serial_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o,
  output logic       idle_o
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
  // Edge detection costs one cycle past the synchronizer, so the half-bit wait is two short.
  localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 2);

  logic      rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;
  logic       fall_s;

  assign fall_s       = rx_prev_q & ~rx_sync_q;
  assign idle_o       = (state_q == ST_IDLE) & ~fall_s;
  assign byte_valid_o = valid_q;
  assign byte_data_o  = data_q;
  assign frame_err_o  = ferr_q;

  // Synchronizer and FSM state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'd0;
      data_q    <= 8'd0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rxd_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state and sampling logic.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (fall_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (timer_q == HALF_END) begin
          timer_d = '0;
          bit_d   = 3'd0;
          if (!rx_sync_q) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (timer_q == BIT_END) begin
          timer_d = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_q == LAST_BIT_IDX) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (timer_q == BIT_END) begin
          timer_d = '0;
          state_d = ST_IDLE;
          if (rx_sync_q) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

endmodule

// File: rtl/miner_serial_rx.sv
// Assembles 64 received bytes into midstate/data2 and pulses new_work when a
// complete frame lands; partial frames are dropped on framing error or idle timeout.
module miner_serial_rx
  import miner_serial_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         RxD,
  output logic [255:0] midstate,
  output logic [255:0] data2,
  output logic         new_work
);

  localparam int unsigned LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TOW = $clog2(LIMIT + 1);
  localparam logic [TOW-1:0] TMO_END = TOW'(LIMIT - 1);

  logic       byte_valid_s;
  logic [7:0] byte_data_s;
  logic       frame_err_s;
  logic       idle_s;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk          (clk),
    .reset        (reset),
    .rxd_i        (RxD),
    .byte_valid_o (byte_valid_s),
    .byte_data_o  (byte_data_s),
    .frame_err_o  (frame_err_s),
    .idle_o       (idle_s)
  );

  // Only 63 bytes need storing: the oldest byte leaves the window as the 64th arrives.
  logic [503:0]   buf_q, buf_d;
  logic [511:0]   new_buf_s;
  logic [5:0]     cnt_q, cnt_d;
  logic [TOW-1:0] tmo_q, tmo_d;
  logic [255:0]   mid_q, mid_d;
  logic [255:0]   d2_q, d2_d;
  logic           nw_q, nw_d;
  logic           tmo_hit_s;

  assign new_buf_s = {buf_q, byte_data_s};
  assign tmo_hit_s = idle_s & (cnt_q != 6'd0) & (tmo_q == TMO_END);
  assign midstate  = mid_q;
  assign data2     = d2_q;
  assign new_work  = nw_q;

  // Frame, timer and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q <= '0;
      cnt_q <= 6'd0;
      tmo_q <= '0;
      mid_q <= 256'd0;
      d2_q  <= 256'd0;
      nw_q  <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      mid_q <= mid_d;
      d2_q  <= d2_d;
      nw_q  <= nw_d;
    end
  end

  // Frame assembly and resync timeout.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    tmo_d = tmo_q;
    mid_d = mid_q;
    d2_d  = d2_q;
    nw_d  = 1'b0;

    if (byte_valid_s) begin
      buf_d = new_buf_s[503:0];
      if (cnt_q == LAST_BYTE_IDX) begin
        mid_d = new_buf_s[511:256];
        d2_d  = new_buf_s[255:0];
        nw_d  = 1'b1;
        cnt_d = 6'd0;
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end else if (frame_err_s || tmo_hit_s) begin
      cnt_d = 6'd0;
    end else begin
      cnt_d = cnt_q;
    end

    if (!idle_s || (cnt_q == 6'd0) || tmo_hit_s) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_miner_serial_rx.sv
// Self-checking bench: table of whole frames plus hand-written corner sequences,
// with a scoreboard queue checked whenever new_work fires.
module tb_miner_serial_rx;

  localparam int CPB = 8;
  localparam int TOB = 4;
  localparam int LAT = 3 + CPB / 2 + 9 * CPB;

  logic         clk;
  logic         reset;
  logic         RxD;
  logic [255:0] midstate;
  logic [255:0] data2;
  logic         new_work;

  miner_serial_rx #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .RxD      (RxD),
    .midstate (midstate),
    .data2    (data2),
    .new_work (new_work)
  );

  typedef struct {
    logic [7:0]   base;
    logic [7:0]   step;
    logic [255:0] mid;
    logic [255:0] d2;
  } vec_t;

  typedef struct {
    logic [255:0] mid;
    logic [255:0] d2;
    int           cyc;
  } exp_t;

  exp_t         exp_q[$];
  vec_t         vecs[3];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  bit           mon_en = 1'b0;
  bit           done = 1'b0;
  logic [255:0] held_mid = 256'd0;
  logic [255:0] held_d2 = 256'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic hold_bit(input logic v);
    RxD = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    hold_bit(1'b0);
    for (int k = 0; k < 8; k++) hold_bit(b[k]);
    hold_bit(stop_bit);
    RxD = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    RxD = 1'b1;
    repeat (n * CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input vec_t v);
    exp_t e;
    for (int j = 0; j < 64; j++) begin
      if (j == 63) begin
        e.mid = v.mid;
        e.d2  = v.d2;
        e.cyc = cyc + LAT;
        exp_q.push_back(e);
      end
      send_byte(v.base + v.step * 8'(j), 1'b1);
    end
  endtask

  initial begin
    vec_t v_a5, v_11;
    vecs[0] = '{8'h00, 8'h01,
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
      256'h202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f};
    vecs[1] = '{8'hC0, 8'h01,
      256'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecfd0d1d2d3d4d5d6d7d8d9dadbdcdddedf,
      256'he0e1e2e3e4e5e6e7e8e9eaebecedeeeff0f1f2f3f4f5f6f7f8f9fafbfcfdfeff};
    vecs[2] = '{8'h5A, 8'h00, {32{8'h5A}}, {32{8'h5A}}};
    v_a5 = '{8'hA5, 8'h00, {32{8'hA5}}, {32{8'hA5}}};
    v_11 = '{8'h11, 8'h00, {32{8'h11}}, {32{8'h11}}};

    RxD   = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    fork
      begin
        chk("reset_midstate", midstate, 256'd0);
        chk("reset_data2", data2, 256'd0);
        chk_int("reset_new_work", int'(new_work), 0);
        mon_en = 1'b1;
        idle_bits(6);

        for (int i = 0; i < 3; i++) send_frame(vecs[i]);

        // partial frame abandoned by idle timeout
        for (int i = 0; i < 10; i++) send_byte(8'(i + 8'h40), 1'b1);
        idle_bits(5);
        send_frame(v_a5);

        // framing error on byte 20
        for (int i = 0; i < 19; i++) send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b0);
        idle_bits(2);
        send_frame(v_11);

        // short low glitch on an idle line
        RxD = 1'b0;
        repeat (2) @(posedge clk);
        #1 RxD = 1'b1;
        idle_bits(3);
        send_frame(vecs[1]);

        // reset in the middle of byte 30
        for (int i = 0; i < 29; i++) send_byte(8'h77, 1'b1);
        RxD = 1'b0;
        repeat (12) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        held_mid = 256'd0;
        held_d2  = 256'd0;
        RxD      = 1'b1;
        chk("midreset_midstate", midstate, 256'd0);
        chk("midreset_data2", data2, 256'd0);
        chk_int("midreset_new_work", int'(new_work), 0);
        idle_bits(20);
        send_frame(vecs[0]);

        idle_bits(3);
        chk_int("pending_expect", exp_q.size(), 0);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (mon_en && !done) begin
            if (new_work) begin
              total++;
              if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_new_work act=1 exp=0 at cyc=%0d", cyc);
              end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("frame_midstate", midstate, e.mid);
                chk("frame_data2", data2, e.d2);
                chk_int("frame_latency", cyc, e.cyc);
                held_mid = e.mid;
                held_d2  = e.d2;
              end
            end else begin
              total++;
              if (midstate !== held_mid || data2 !== held_d2) begin
                bad++;
                $display("FAIL outputs_stable cyc=%0d act=%h/%h exp=%h/%h",
                         cyc, midstate, data2, held_mid, held_d2);
              end
            end
          end
        end
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
